// File: rtl/dbus_store_buffer_pkg.sv
// Shared types for the dbus posted-write buffer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Contents: dbus request/response structs, buffered store entry, drain/load FSM states.
package dbus_store_buffer_pkg;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] word_t;
   typedef logic [3:0]  strobe_t;
   typedef logic [2:0]  msize_t;

   typedef struct packed {
      logic    valid;
      addr_t   addr;
      msize_t  size;
      strobe_t strobe;
      word_t   data;
   } dbus_req_t;

   typedef struct packed {
      logic  addr_ok;
      logic  data_ok;
      word_t data;
   } dbus_resp_t;

   typedef struct packed {
      addr_t   addr;
      msize_t  size;
      strobe_t strobe;
      word_t   data;
   } stb_entry_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      D_REQ  = 3'd1,
      D_RESP = 3'd2,
      L_REQ  = 3'd3,
      L_RESP = 3'd4
   } stb_state_t;

endpackage

// File: rtl/dbus_store_buffer_stb_fifo.sv
// Circular buffer of buffered stores, popped in push order.
// Latency: pushed entry visible at head the cycle after push (when buffer was empty).
// Backpressure: caller must not push when full unless popping in the same cycle.
// Ports: clk_i/rstn_i; push_i+push_dat_i write at tail; pop_i retires head; head_o, full_o,
//   empty_o, count_o status. With STB_LOAD_BYPASS_EN defined, vld_o/waddr_o expose every
//   slot's occupancy and word address for load address matching.
module stb_fifo
   import dbus_store_buffer_pkg::*;
#(
   parameter int  DEPTH = 4,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                        clk_i,
   input  logic                        rstn_i,
`ifdef STB_LOAD_BYPASS_EN
   output logic [DEPTH-1:0]            vld_o,
   output logic [DEPTH-1:0][29:0]      waddr_o,
`endif
   input  logic                        push_i,
   input  stb_entry_t                  push_dat_i,
   input  logic                        pop_i,
   output stb_entry_t                  head_o,
   output logic                        full_o,
   output logic                        empty_o,
   output logic [PTR_W:0]              count_o
);

   stb_entry_t        ent_q [DEPTH];
   logic [PTR_W-1:0]  head_q, tail_q;
   logic [PTR_W:0]    cnt_q;

   // Explicit wrap keeps DEPTH=1 pinned at slot 0.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Payload needs no reset: occupancy is carried entirely by the pointers and count.
   always_ff @(posedge clk_i) begin
      if (push_i) ent_q[tail_q] <= push_dat_i;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push_i) tail_q <= ptr_inc(tail_q);
         if (pop_i)  head_q <= ptr_inc(head_q);
         case ({push_i, pop_i})
            2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
            2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign head_o  = ent_q[head_q];
   assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;

`ifdef STB_LOAD_BYPASS_EN
   // A slot is occupied when its distance from head (mod DEPTH) is below the count.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         vld_o[i]   = ({1'b0, PTR_W'(i) - head_q} < cnt_q);
         waddr_o[i] = ent_q[i].addr[31:2];
      end
   end
`endif

endmodule

// File: rtl/dbus_store_buffer.sv
// Posted-write buffer between core dbus and memory converter; loads ordered against stores.
// Latency: store addr_ok combinational, data_ok one cycle later; loads pass through once issued.
// Backpressure: addr_ok withheld when full (unless a drain completes that cycle) or a load owns dreq.
// Ports: clk/resetn; creq/cresp core side; dreq/dresp memory side; empty (no entries, FSM idle);
//   count (valid entries). Option STB_LOAD_BYPASS_EN lets non-conflicting loads pass buffered stores.
module dbus_store_buffer
   import dbus_store_buffer_pkg::*;
#(
   parameter int  DEPTH = 4,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic           clk,
   input  logic           resetn,
   input  dbus_req_t      creq,
   output dbus_resp_t     cresp,
   output dbus_req_t      dreq,
   input  dbus_resp_t     dresp,
   output logic           empty,
   output logic [PTR_W:0] count
);

   stb_state_t state_q, state_d;
   logic       ack_q;
   stb_entry_t push_ent, head;
   logic       fifo_full, fifo_empty;
   logic       is_store, load_busy, drain_done, st_acc, ld_clear, load_go;

   assign is_store  = |creq.strobe;
   assign load_busy = (state_q == L_REQ) || (state_q == L_RESP);

   // Covers both the split handshake and memory completing in the request cycle.
   assign drain_done = ((state_q == D_REQ) && dresp.addr_ok && dresp.data_ok) ||
                       ((state_q == D_RESP) && dresp.data_ok);

   // A completing drain frees a slot in the same cycle, so a full buffer can still accept.
   assign st_acc = creq.valid && is_store && !load_busy && (!fifo_full || drain_done);

   assign push_ent = '{addr: creq.addr, size: creq.size, strobe: creq.strobe, data: creq.data};

`ifdef STB_LOAD_BYPASS_EN
   logic [DEPTH-1:0]       ent_vld;
   logic [DEPTH-1:0][29:0] ent_waddr;
   logic                   ld_hit;

   always_comb begin
      ld_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_vld[i] && (ent_waddr[i] == creq.addr[31:2])) ld_hit = 1'b1;
      end
   end
   assign ld_clear = fifo_empty || !ld_hit;
`else
   assign ld_clear = fifo_empty;
`endif

   // Only starts from IDLE, so an in-progress drain always finishes first.
   assign load_go = (state_q == IDLE) && creq.valid && !is_store && ld_clear;

   stb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i      (clk),
      .rstn_i     (resetn),
`ifdef STB_LOAD_BYPASS_EN
      .vld_o      (ent_vld),
      .waddr_o    (ent_waddr),
`endif
      .push_i     (st_acc),
      .push_dat_i (push_ent),
      .pop_i      (drain_done),
      .head_o     (head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (count)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (load_go)          state_d = L_REQ;
            else if (!fifo_empty) state_d = D_REQ;
         end
         D_REQ:  if (dresp.addr_ok) state_d = dresp.data_ok ? IDLE : D_RESP;
         D_RESP: if (dresp.data_ok) state_d = IDLE;
         L_REQ:  if (dresp.addr_ok) state_d = dresp.data_ok ? IDLE : L_RESP;
         L_RESP: if (dresp.data_ok) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= st_acc;
      end
   end

   always_comb begin
      cresp         = '0;
      dreq          = '0;
      cresp.addr_ok = st_acc;
      cresp.data_ok = ack_q;
      case (state_q)
         D_REQ: begin
            dreq.valid  = 1'b1;
            dreq.addr   = head.addr;
            dreq.size   = head.size;
            dreq.strobe = head.strobe;
            dreq.data   = head.data;
         end
         L_REQ: begin
            dreq          = creq;
            cresp.addr_ok = dresp.addr_ok;
            cresp.data_ok = dresp.addr_ok && dresp.data_ok;
            cresp.data    = dresp.data;
         end
         L_RESP: begin
            cresp.data_ok = dresp.data_ok;
            cresp.data    = dresp.data;
         end
         default: ;
      endcase
   end

   assign empty = fifo_empty && (state_q == IDLE);

endmodule

// File: tb/tb_dbus_store_buffer.sv
// Directed bench for dbus_store_buffer with a behavioural memory and a transaction scoreboard.
// Memory accepts dreq at +2 after each posedge; addr_ok can be held off, data_ok after mem_lat cycles.
// Expected memory transactions are queued at stimulus time and compared with what memory observed.
module tb_dbus_store_buffer;
   import dbus_store_buffer_pkg::*;

   logic       clk, resetn;
   dbus_req_t  creq, dreq;
   dbus_resp_t cresp, dresp;
   logic       empty;
   logic [2:0] count;

   dbus_store_buffer #(.DEPTH(4)) dut (
      .clk    (clk),
      .resetn (resetn),
      .creq   (creq),
      .cresp  (cresp),
      .dreq   (dreq),
      .dresp  (dresp),
      .empty  (empty),
      .count  (count)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } xact_t;

   xact_t exp_q[$];
   xact_t obs_q[$];
   int    pass_cnt = 0;
   int    tot_cnt  = 0;

   logic        mem_hold;
   int          mem_lat;
   logic [31:0] mem [logic [29:0]];
   logic        mem_busy;
   int          mem_cnt;
   logic [31:0] mem_rdata;
   xact_t       mem_rec;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural memory converter.
   initial begin
      dresp    = '0;
      mem_busy = 1'b0;
      mem_cnt  = 0;
      forever begin
         @(posedge clk);
         #2;
         dresp = '0;
         if (!resetn) begin
            mem_busy = 1'b0;
         end else if (mem_busy) begin
            if (mem_cnt <= 1) begin
               dresp.data_ok = 1'b1;
               dresp.data    = mem_rdata;
               mem_busy      = 1'b0;
            end else begin
               mem_cnt = mem_cnt - 1;
            end
         end else if (dreq.valid && !mem_hold) begin
            dresp.addr_ok = 1'b1;
            mem_rec.we    = (dreq.strobe != 4'h0);
            mem_rec.addr  = dreq.addr;
            mem_rec.data  = mem_rec.we ? dreq.data : 32'h0;
            obs_q.push_back(mem_rec);
            if (mem_rec.we) begin
               mem[dreq.addr[31:2]] = dreq.data;
               mem_rdata = 32'h0;
            end else begin
               mem_rdata = mem.exists(dreq.addr[31:2]) ? mem[dreq.addr[31:2]] : 32'h0;
            end
            if (mem_lat == 0) begin
               dresp.data_ok = 1'b1;
               dresp.data    = mem_rdata;
            end else begin
               mem_busy = 1'b1;
               mem_cnt  = mem_lat;
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tot_cnt++;
      assert (obs === expv) begin
         pass_cnt++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, output int waited);
      int k = 0;
      step();
      creq = '{valid: 1'b1, addr: a, size: 3'd2, strobe: 4'hF, data: d};
      exp_q.push_back('{we: 1'b1, addr: a, data: d});
      @(negedge clk);
      while (cresp.addr_ok !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      waited = k;
      chk("store_addr_ok", 32'(cresp.addr_ok), 32'd1);
      step();
      creq = '0;
      @(negedge clk);
      chk("store_data_ok", 32'(cresp.data_ok), 32'd1);
      chk("store_data_zero", cresp.data, 32'h0);
   endtask

   task automatic do_load(input logic [31:0] a, output logic [31:0] d, output int cnt_at_issue);
      int k = 0;
      step();
      creq = '{valid: 1'b1, addr: a, size: 3'd2, strobe: 4'h0, data: 32'h0};
      exp_q.push_back('{we: 1'b0, addr: a, data: 32'h0});
      @(negedge clk);
      while (cresp.addr_ok !== 1'b1 && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk("load_addr_ok", 32'(cresp.addr_ok), 32'd1);
      chk("load_dreq_addr", dreq.addr, a);
      cnt_at_issue = int'(count);
      step();
      creq = '0;
      k = 0;
      @(negedge clk);
      while (cresp.data_ok !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("load_data_ok", 32'(cresp.data_ok), 32'd1);
      d = cresp.data;
   endtask

   task automatic wait_empty(input string tag);
      int k = 0;
      @(negedge clk);
      while (empty !== 1'b1 && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(empty), 32'd1);
   endtask

   task automatic drain_check(input string tag);
      xact_t o, e;
      chk({tag, "_n"}, obs_q.size(), exp_q.size());
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         chk({tag, "_we"}, 32'(o.we), 32'(e.we));
         chk({tag, "_addr"}, o.addr, e.addr);
         chk({tag, "_data"}, o.data, e.data);
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int          w, cnt_i;
      logic [31:0] ld;
      xact_t       xr, xw;
      int          k;

      resetn   = 1'b0;
      creq     = '0;
      mem_hold = 1'b0;
      mem_lat  = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_data_ok", 32'(cresp.data_ok), 32'd0);
      chk("rst_dreq_valid", 32'(dreq.valid), 32'd0);
      step();
      resetn = 1'b1;

      // Single store: same-cycle accept, dreq stable while memory stalls.
      mem_hold = 1'b1;
      mem_lat  = 1;
      do_store(32'h8000_0010, 32'hDEAD_BEEF, w);
      chk("t1_addr_ok_same_cycle", 32'(w), 32'd0);
      chk("t1_count", 32'(count), 32'd1);
      repeat (2) @(negedge clk);
      chk("t1_dreq_valid", 32'(dreq.valid), 32'd1);
      chk("t1_dreq_addr", dreq.addr, 32'h8000_0010);
      chk("t1_dreq_data", dreq.data, 32'hDEAD_BEEF);
      chk("t1_dreq_strobe", 32'(dreq.strobe), 32'hF);
      @(negedge clk);
      chk("t1_dreq_addr_held", dreq.addr, 32'h8000_0010);
      chk("t1_dreq_data_held", dreq.data, 32'hDEAD_BEEF);
      step();
      mem_hold = 1'b0;
      wait_empty("t1_empty");
      drain_check("t1");

      // Full buffer: fifth store waits, accepted in the cycle the first drain completes.
      mem_hold = 1'b1;
      mem_lat  = 2;
      for (int i = 0; i < 4; i++) do_store(32'h1000 + 32'(4 * i), 32'hA000_0000 + 32'(i), w);
      @(negedge clk);
      chk("t2_count_full", 32'(count), 32'd4);
      step();
      creq = '{valid: 1'b1, addr: 32'h1010, size: 3'd2, strobe: 4'hF, data: 32'hA000_0004};
      exp_q.push_back('{we: 1'b1, addr: 32'h1010, data: 32'hA000_0004});
      repeat (3) begin
         @(negedge clk);
         chk("t2_full_addr_ok", 32'(cresp.addr_ok), 32'd0);
      end
      chk("t2_count_held", 32'(count), 32'd4);
      step();
      mem_hold = 1'b0;
      k = 0;
      @(negedge clk);
      while (cresp.addr_ok !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("t2_fifth_addr_ok", 32'(cresp.addr_ok), 32'd1);
      chk("t2_accept_on_drain", 32'(dresp.data_ok), 32'd1);
      step();
      creq = '0;
      @(negedge clk);
      chk("t2_fifth_data_ok", 32'(cresp.data_ok), 32'd1);
      chk("t2_count_pushpop", 32'(count), 32'd4);
      wait_empty("t2_empty");
      drain_check("t2");

      // Load after store to the same address waits for the drain.
      mem_hold = 1'b0;
      mem_lat  = 3;
      do_store(32'h0000_0100, 32'h1234_5678, w);
      do_load(32'h0000_0100, ld, cnt_i);
      chk("t3_count_at_issue", 32'(cnt_i), 32'd0);
      chk("t3_load_data", ld, 32'h1234_5678);
      wait_empty("t3_empty");
      drain_check("t3");

      // Non-matching load behind buffered stores.
      mem_hold = 1'b1;
      mem_lat  = 2;
      do_store(32'h0000_0200, 32'h0000_0200, w);
      do_store(32'h0000_0204, 32'h0000_0204, w);
      mem_hold = 1'b0;
      do_load(32'h0000_0300, ld, cnt_i);
`ifdef STB_LOAD_BYPASS_EN
      chk("t4_bypass_count_at_issue", 32'(cnt_i), 32'd1);
      xr = exp_q.pop_back();
      xw = exp_q.pop_back();
      exp_q.push_back(xr);
      exp_q.push_back(xw);
`else
      chk("t4_strict_count_at_issue", 32'(cnt_i), 32'd0);
`endif
      chk("t4_load_data", ld, 32'h0);
      wait_empty("t4_empty");
      drain_check("t4");

      // Matching load always waits for empty and sees the newest store.
      mem_hold = 1'b1;
      do_store(32'h0000_0204, 32'hCAFE_0204, w);
      do_store(32'h0000_0208, 32'hCAFE_0208, w);
      mem_hold = 1'b0;
      do_load(32'h0000_0204, ld, cnt_i);
      chk("t4b_count_at_issue", 32'(cnt_i), 32'd0);
      chk("t4b_load_data", ld, 32'hCAFE_0204);
      wait_empty("t4b_empty");
      drain_check("t4b");

      // Zero-latency memory, eight stores: pointers wrap twice.
      mem_hold = 1'b1;
      mem_lat  = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 4) mem_hold = 1'b0;
         do_store(32'h0000_0400 + 32'(4 * i), 32'h5000_0000 + 32'(i), w);
      end
      wait_empty("t5_empty");
      chk("t5_count", 32'(count), 32'd0);
      drain_check("t5");

      // Asynchronous reset while a drain waits for data_ok.
      mem_hold = 1'b1;
      mem_lat  = 6;
      for (int i = 0; i < 3; i++) do_store(32'h0000_0600 + 32'(4 * i), 32'h6000_0000 + 32'(i), w);
      @(negedge clk);
      chk("t6_count3", 32'(count), 32'd3);
      step();
      mem_hold = 1'b0;
      k = 0;
      @(negedge clk);
      while (dresp.addr_ok !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("t6_grant", 32'(dresp.addr_ok), 32'd1);
      @(negedge clk);
      chk("t6_dresp_state_valid", 32'(dreq.valid), 32'd0);
      #1 resetn = 1'b0;
      #1;
      chk("t6_rst_count", 32'(count), 32'd0);
      chk("t6_rst_dreq_valid", 32'(dreq.valid), 32'd0);
      chk("t6_rst_data_ok", 32'(cresp.data_ok), 32'd0);
      chk("t6_rst_empty", 32'(empty), 32'd1);
      step();
      step();
      resetn = 1'b1;
      exp_q.delete();
      obs_q.delete();
      mem_lat = 1;
      do_store(32'h0000_0700, 32'h7777_0000, w);
      wait_empty("t6_after_empty");
      drain_check("t6_after");

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
